// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and FIFO pointer blocks.
// Functions work on the widest supported vector; narrower callers zero-extend.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits pass through the prefix XOR unchanged, so zero-extension is safe.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
        logic [GRAY_MAX_WIDTH-1:0] b;
        b = {GRAY_MAX_WIDTH{1'b0}};
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin_n.sv
// Combinational Gray-to-binary converter: prefix XOR from the MSB downwards.
module gray_to_bin_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] chain_s;

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        chain_s = {WIDTH{1'b0}};
        chain_s[WIDTH-1] = gray_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            chain_s[i] = chain_s[i+1] ^ gray_i[i];
        end
    end

    assign bin_o = chain_s;

endmodule

// File: rtl/gray_code_counter.sv
// Up/down counter with wrap or saturate, binary/Gray parallel load,
// and registered binary and Gray views that always change on the same edge.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0,
    parameter int INIT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(INIT_BIN)));
    localparam logic [WIDTH-1:0] ONES      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] din_bin_s;

    gray_to_bin_n #(.WIDTH(WIDTH)) u_din_g2b (
        .gray_i (din),
        .bin_o  (din_bin_s)
    );

    // Next-state selection: load beats step; a step at the terminal value wraps or holds.
    always_comb begin
        bin_d = bin_q;
        ovf_d = 1'b0;
        if (load) begin
            bin_d = load_gray ? din_bin_s : din;
        end else if (en) begin
            if (up) begin
                if (bin_q == ONES) begin
                    ovf_d = 1'b1;
                    bin_d = SATURATE ? bin_q : ZERO;
                end else begin
                    bin_d = bin_q + WIDTH'(1);
                end
            end else begin
                if (bin_q == ZERO) begin
                    ovf_d = 1'b1;
                    bin_d = SATURATE ? bin_q : ONES;
                end else begin
                    bin_d = bin_q - WIDTH'(1);
                end
            end
        end else begin
            bin_d = bin_q;
        end
        // Gray is built from the next binary value so both views register together.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State registers with synchronous reset to INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench: four counter configurations share one stimulus stream
// and are compared against an arithmetic reference model.
module tb_gray_code_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, load, load_gray;
    logic [15:0] din;

    logic [3:0]  a_bin, a_gray, b_bin, b_gray;
    logic [1:0]  c_bin, c_gray;
    logic [15:0] d_bin, d_gray;
    logic        a_ovf, b_ovf, c_ovf, d_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam int              MW[4] = '{4, 4, 2, 16};
    localparam bit              MS[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam longint unsigned MI[4] = '{64'd5, 64'd0, 64'd1, 64'd48879};

    gray_code_counter #(.WIDTH(4), .SATURATE(1'b0), .INIT(5)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .din(din[3:0]), .bin(a_bin), .gray(a_gray), .ovf(a_ovf));
    gray_code_counter #(.WIDTH(4), .SATURATE(1'b1), .INIT(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .din(din[3:0]), .bin(b_bin), .gray(b_gray), .ovf(b_ovf));
    gray_code_counter #(.WIDTH(2), .SATURATE(1'b0), .INIT(1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .din(din[1:0]), .bin(c_bin), .gray(c_gray), .ovf(c_ovf));
    gray_code_counter #(.WIDTH(16), .SATURATE(1'b1), .INIT(48879)) dut_d (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .din(din), .bin(d_bin), .gray(d_gray), .ovf(d_ovf));

    initial forever #5 clk = ~clk;

    // Reference model: returns {ovf, next_count} from the counting rules.
    function automatic logic [64:0] mnext(input int w, input bit sat, input longint unsigned init,
                                          input longint unsigned b, input bit r, input bit ld,
                                          input bit lg, input bit e, input bit u,
                                          input longint unsigned d);
        longint unsigned mask, nb;
        mask = (64'd1 << w) - 64'd1;
        nb   = b;
        if (r) return {1'b0, init};
        if (ld) begin
            d = d & mask;
            if (lg) begin
                nb = 64'd0;
                for (int i = 0; i < w; i++)
                    if (($countones(d >> i) % 2) == 1) nb = nb | (64'd1 << i);
            end else begin
                nb = d;
            end
            return {1'b0, nb};
        end
        if (e) begin
            if (u) begin
                if (b == mask) return {1'b1, (sat ? b : 64'd0)};
                return {1'b0, b + 64'd1};
            end
            if (b == 64'd0) return {1'b1, (sat ? b : mask)};
            return {1'b0, b - 64'd1};
        end
        return {1'b0, b};
    endfunction

    logic [64:0] nxt[4];
    logic [63:0] mb[4] = '{64'd0, 64'd0, 64'd0, 64'd0};
    logic        mo[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [63:0] db[4], dg[4];
    logic        dov[4];

    always_comb begin
        for (int k = 0; k < 4; k++)
            nxt[k] = mnext(MW[k], MS[k], MI[k], mb[k], rst, load, load_gray, en, up, 64'(din));
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            mb[k] <= nxt[k][63:0];
            mo[k] <= nxt[k][64];
        end
    end

    always_comb begin
        db[0] = 64'(a_bin); dg[0] = 64'(a_gray); dov[0] = a_ovf;
        db[1] = 64'(b_bin); dg[1] = 64'(b_gray); dov[1] = b_ovf;
        db[2] = 64'(c_bin); dg[2] = 64'(c_gray); dov[2] = c_ovf;
        db[3] = 64'(d_bin); dg[3] = 64'(d_gray); dov[3] = d_ovf;
    end

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; load = 1'b1; up = 1'b1; load_gray = 1'b0;
        din = 16'($urandom);
        repeat (2) @(negedge clk);
        tests_run++;
        if (a_bin !== 4'b0101) begin
            tests_failed++; $display("FAIL reset_bin actual=%b required=0101", a_bin);
        end
        tests_run++;
        if (a_gray !== 4'b0111) begin
            tests_failed++; $display("FAIL reset_gray actual=%b required=0111", a_gray);
        end
        tests_run++;
        if (a_ovf !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ovf actual=%b required=0", a_ovf);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (db[k] !== mb[k] || dg[k] !== (mb[k] ^ (mb[k] >> 1)) || dov[k] !== mo[k]) begin
                tests_failed++;
                $display("FAIL reset_inst%0d bin=%h/%h gray=%h/%h ovf=%b/%b", k,
                         db[k], mb[k], dg[k], mb[k] ^ (mb[k] >> 1), dov[k], mo[k]);
            end
        end
        rst = 1'b0; en = 1'b0; load = 1'b0;
    endtask

    task automatic test_up_wrap;
        logic [3:0] gtab[16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        logic [3:0] prev;
        load = 1'b1; load_gray = 1'b0; din = 16'h0000; en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_gray !== 4'b0000) begin
            tests_failed++; $display("FAIL wrap_start actual=%b required=0000", a_gray);
        end
        prev = a_gray;
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int s = 1; s <= 17; s++) begin
            @(negedge clk);
            tests_run++;
            if (a_gray !== gtab[s % 16] || a_ovf !== (s == 16)) begin
                tests_failed++;
                $display("FAIL wrap_step%0d gray=%b required=%b ovf=%b required=%b",
                         s, a_gray, gtab[s % 16], a_ovf, (s == 16));
            end
            tests_run++;
            if ($countones(a_gray ^ prev) != 1) begin
                tests_failed++;
                $display("FAIL wrap_onebit%0d flipped=%0d required=1", s, $countones(a_gray ^ prev));
            end
            prev = a_gray;
        end
        en = 1'b0;
    endtask

    task automatic test_down_sat;
        logic [3:0] ebin[4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic       eovf[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        load = 1'b1; load_gray = 1'b0; din = 16'h0002;
        @(negedge clk);
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            tests_run++;
            if (b_bin !== ebin[s] || b_ovf !== eovf[s] || b_gray !== ebin[s]) begin
                tests_failed++;
                $display("FAIL sat_down%0d bin=%b required=%b gray=%b ovf=%b required=%b",
                         s, b_bin, ebin[s], b_gray, b_ovf, eovf[s]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_gray_load;
        load = 1'b1; load_gray = 1'b1; din = 16'h000D; en = 1'b1; up = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a_bin !== 4'b1001 || a_gray !== 4'b1101 || a_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL gray_load bin=%b required=1001 gray=%b required=1101 ovf=%b required=0",
                     a_bin, a_gray, a_ovf);
        end
        tests_run++;
        if (d_gray !== 16'h000D || d_bin !== 16'h0009) begin
            tests_failed++;
            $display("FAIL gray_load16 bin=%h required=0009 gray=%h required=000d", d_bin, d_gray);
        end
        load = 1'b0; load_gray = 1'b0; en = 1'b0;
    endtask

    task automatic test_bin_load_dir;
        logic [3:0] ebin[4]  = '{4'b0111, 4'b1000, 4'b0111, 4'b0110};
        logic [3:0] egray[4] = '{4'b0100, 4'b1100, 4'b0100, 4'b0101};
        load = 1'b1; load_gray = 1'b0; din = 16'h0007; en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            tests_run++;
            if (a_bin !== ebin[s] || a_gray !== egray[s]) begin
                tests_failed++;
                $display("FAIL dir_flip%0d bin=%b required=%b gray=%b required=%b",
                         s, a_bin, ebin[s], a_gray, egray[s]);
            end
            load = 1'b0; en = 1'b1; up = (s == 0);
        end
        en = 1'b0;
    endtask

    task automatic test_random;
        for (int c = 0; c < 10000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            load      = ($urandom_range(0, 9) == 0);
            load_gray = 1'($urandom);
            en        = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) == 0) up = ~up;
            case ($urandom_range(0, 3))
                0:       din = 16'hFFFF;
                1:       din = 16'h0000;
                default: din = 16'($urandom);
            endcase
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (db[k] !== mb[k] || dg[k] !== (mb[k] ^ (mb[k] >> 1)) || dov[k] !== mo[k]) begin
                    tests_failed++;
                    $display("FAIL rand_inst%0d cyc%0d bin=%h/%h gray=%h/%h ovf=%b/%b", k, c,
                             db[k], mb[k], dg[k], mb[k] ^ (mb[k] >> 1), dov[k], mo[k]);
                end
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_gray = 1'b0; din = 16'h0000;
        test_reset;
        test_up_wrap;
        test_down_sat;
        test_gray_load;
        test_bin_load_dir;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
